// File: rtl/fp_multiply_arbiter_pkg.sv
// Shared accelerator constants and width helpers for the multiply arbiter slice.
package fp_multiply_arbiter_pkg;

  localparam int FP_WIDTH = 32;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of an outstanding-operation counter able to hold max_out.
  function automatic int cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/fp_multiply_arbiter_if.sv
// Requester/result bundle between the requesters (master) and the arbiter (slave).
interface fp_multiply_arbiter_if
  import fp_multiply_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_w(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]          reqValidIn;
  logic [NUM_REQ*FP_WIDTH-1:0] reqDataAIn;
  logic [NUM_REQ*FP_WIDTH-1:0] reqDataBIn;
  logic [NUM_REQ-1:0]          reqReadyOut;
  logic                        resValidOut;
  logic [ID_W-1:0]             resIdOut;
  logic [FP_WIDTH-1:0]         resDataOut;
  logic                        busyOut;

  modport master (
    output reqValidIn, reqDataAIn, reqDataBIn,
    input  reqReadyOut, resValidOut, resIdOut, resDataOut, busyOut
  );

  modport slave (
    input  reqValidIn, reqDataAIn, reqDataBIn,
    output reqReadyOut, resValidOut, resIdOut, resDataOut, busyOut
  );

endinterface

// File: rtl/fp_multiply_arbiter_fmul.sv
// Pipelined IEEE-754 single-precision multiplier, round-to-nearest-even,
// with subnormal inputs and outputs; product appears LATENCY cycles after operands.
module floating_point_multiply
  import fp_multiply_arbiter_pkg::*;
#(
  parameter int LATENCY = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [FP_WIDTH-1:0] i_a,
  input  logic [FP_WIDTH-1:0] i_b,
  output logic [FP_WIDTH-1:0] o_result
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, guard, sticky, sticky_x, rnd;
    logic [23:0] ma, mb;
    logic [47:0] p, pn, mask;
    logic [31:0] packed_v, res;
    int          ea, eb, lead, e, sh;
    s        = a[31] ^ b[31];
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero   = (a[30:0] == 31'd0);
    b_zero   = (b[30:0] == 31'd0);
    ma       = {(a[30:23] != 8'd0), a[22:0]};
    mb       = {(b[30:23] != 8'd0), b[22:0]};
    ea       = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
    eb       = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
    p        = {24'd0, ma} * {24'd0, mb};
    lead     = 0;
    for (int i = 0; i < 48; i++) begin
      if (p[i]) lead = i;
    end
    // Biased exponent of the value 1.x * 2^(lead + ea + eb - 300).
    e        = lead + ea + eb - 173;
    pn       = p << (47 - lead);
    sticky_x = 1'b0;
    if (e < 1) begin
      // Denormalise: shift right, folding lost bits into sticky.
      sh = 1 - e;
      if (sh > 47) begin
        sticky_x = |pn;
        pn       = 48'd0;
      end else begin
        mask     = (48'd1 << sh) - 48'd1;
        sticky_x = |(pn & mask);
        pn       = pn >> sh;
      end
      e = 0;
    end
    guard    = pn[23];
    sticky   = (|pn[22:0]) | sticky_x;
    rnd      = guard & (sticky | pn[24]);
    // Rounding carry ripples into the exponent field (subnormal->normal, overflow->inf).
    packed_v = {1'b0, e[7:0], pn[46:24]} + {31'd0, rnd};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res = 32'h7FC0_0000;
    end else if (a_inf || b_inf || (e > 254)) begin
      res = {s, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      res = {s, 31'd0};
    end else begin
      res = {s, packed_v[30:0]};
    end
    return res;
  endfunction

  logic [FP_WIDTH-1:0] w_prod;
  logic [FP_WIDTH-1:0] r_pipe [LATENCY];

  assign w_prod = fp_mul(i_a, i_b);

  // Carry the product through LATENCY register stages
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < LATENCY; k++) r_pipe[k] <= {FP_WIDTH{1'b0}};
    end else begin
      r_pipe[0] <= w_prod;
      for (int k = 1; k < LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_result = r_pipe[LATENCY-1];

endmodule

// File: rtl/fp_multiply_arbiter.sv
// Round-robin arbiter sharing one pipelined FP multiplier among NUM_REQ requesters,
// with per-requester in-flight limits and an index pipeline tagging each result.
module fp_multiply_arbiter
  import fp_multiply_arbiter_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int LATENCY         = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                 clkIn,
  input  logic                 rstNIn,
  fp_multiply_arbiter_if.slave bus
);

  localparam int               ID_W    = id_w(NUM_REQ);
  localparam int               CNT_W   = cnt_w(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [ID_W-1:0]     r_ptr;
  logic [CNT_W-1:0]    r_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]  w_elig, w_grant, w_dec;
  logic [ID_W-1:0]     w_gid;
  logic                w_gnt_any;
  logic                r_iss_valid;
  logic [ID_W-1:0]     r_iss_id;
  logic [FP_WIDTH-1:0] r_iss_a, r_iss_b;
  logic [LATENCY-1:0]  r_pv;
  logic [ID_W-1:0]     r_pid [LATENCY];
  logic                r_res_valid;
  logic [ID_W-1:0]     r_res_id;
  logic [FP_WIDTH-1:0] r_res_data;
  logic [FP_WIDTH-1:0] w_mul_res;
  logic                w_mul_rst;

  // First eligible requester at or after ptr, wrapping around.
  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                                 input logic [ID_W-1:0]    ptr);
    logic [NUM_REQ-1:0] g;
    logic               found;
    int                 idx;
    g     = {NUM_REQ{1'b0}};
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && elig[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Eligibility: valid, below the in-flight limit, and not held in reset
  always_comb begin
    w_elig = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++)
      w_elig[i] = bus.reqValidIn[i] && (r_cnt[i] < CNT_MAX) && rstNIn;
  end

  // Grant vector, its encoded index, and the per-requester result-return strobe
  always_comb begin
    w_grant = rr_pick(w_elig, r_ptr);
    w_gid   = {ID_W{1'b0}};
    w_dec   = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gid    = w_gid | (w_grant[i] ? ID_W'(i) : {ID_W{1'b0}});
      w_dec[i] = r_res_valid && (r_res_id == ID_W'(i));
    end
  end

  assign w_gnt_any       = |w_grant;
  assign bus.reqReadyOut = w_grant;

  // Move the round-robin pointer just past the requester that was granted
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_ptr <= {ID_W{1'b0}};
    end else if (w_gnt_any) begin
      r_ptr <= (w_gid == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : w_gid + ID_W'(1);
    end
  end

  // Track in-flight operations per requester; simultaneous issue and return cancel
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (w_dec[i] && !w_grant[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  // Issue-stage control, index pipeline aligned with the multiplier, and result tag
  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      r_iss_valid <= 1'b0;
      r_iss_id    <= {ID_W{1'b0}};
      r_pv        <= {LATENCY{1'b0}};
      for (int k = 0; k < LATENCY; k++) r_pid[k] <= {ID_W{1'b0}};
      r_res_valid <= 1'b0;
      r_res_id    <= {ID_W{1'b0}};
    end else begin
      r_iss_valid <= w_gnt_any;
      r_iss_id    <= w_gid;
      r_pv[0]     <= r_iss_valid;
      r_pid[0]    <= r_iss_id;
      for (int k = 1; k < LATENCY; k++) begin
        r_pv[k]  <= r_pv[k-1];
        r_pid[k] <= r_pid[k-1];
      end
      r_res_valid <= r_pv[LATENCY-1];
      r_res_id    <= r_pid[LATENCY-1];
    end
  end

  // Data-only registers: operands captured on a grant, product captured every cycle
  always_ff @(posedge clkIn) begin
    if (w_gnt_any) begin
      r_iss_a <= bus.reqDataAIn[int'(w_gid)*FP_WIDTH +: FP_WIDTH];
      r_iss_b <= bus.reqDataBIn[int'(w_gid)*FP_WIDTH +: FP_WIDTH];
    end
    r_res_data <= w_mul_res;
  end

  assign w_mul_rst = ~rstNIn;

  floating_point_multiply #(
    .LATENCY (LATENCY)
  ) u_fmul (
    .i_clk    (clkIn),
    .i_rst    (w_mul_rst),
    .i_a      (r_iss_a),
    .i_b      (r_iss_b),
    .o_result (w_mul_res)
  );

  assign bus.resValidOut = r_res_valid;
  assign bus.resIdOut    = r_res_id;
  assign bus.resDataOut  = r_res_data;
  assign bus.busyOut     = r_iss_valid | (|r_pv);

endmodule

// File: tb/tb_fp_multiply_arbiter.sv
// Directed bench for fp_multiply_arbiter: grant order, latency, in-flight limits,
// product values and mid-operation reset, with a result scoreboard.
module tb_fp_multiply_arbiter;
  import fp_multiply_arbiter_pkg::*;

  localparam int NR   = 4;
  localparam int LAT  = 8;
  localparam int MAXO = 4;

  typedef struct { int id; logic [31:0] data; int cyc; } exp_t;
  typedef struct { int id; int cyc; } gnt_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  exp_t        exp_q [$];
  gnt_t        glog  [$];
  exp_t        mon_e;
  logic [31:0] p_tab [NR];
  int          cyc    = 0;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_res  = 0;
  int          n0, b;
  int          offs [8];

  always #5 clk = ~clk;

  fp_multiply_arbiter_if #(.NUM_REQ(NR)) bus ();

  fp_multiply_arbiter #(
    .NUM_REQ         (NR),
    .LATENCY         (LAT),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clkIn  (clk),
    .rstNIn (rst_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Grant log and result scoreboard; grants seen at negedge transfer on the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.reqReadyOut != '0) begin
        chk("ready_onehot", 32'($countones(bus.reqReadyOut)), 32'd1);
        chk("ready_needs_valid", 32'(bus.reqReadyOut & ~bus.reqValidIn), 32'd0);
      end
      if (bus.resValidOut) begin
        n_res++;
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("res_id", 32'(bus.resIdOut), 32'(mon_e.id));
          chk("res_data", bus.resDataOut, mon_e.data);
          chk("res_latency", 32'(cyc), 32'(mon_e.cyc));
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.reqValidIn[i] && bus.reqReadyOut[i]) begin
          glog.push_back('{i, cyc});
          exp_q.push_back('{i, p_tab[i], cyc + LAT + 2});
        end
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] bb,
                        input logic [31:0] p);
    p_tab[i] = p;
    bus.reqDataAIn[32*i +: 32] = a;
    bus.reqDataBIn[32*i +: 32] = bb;
  endtask

  // Raise valid for each requester in m and drop each one after its transfer.
  task automatic drive_mask(input logic [NR-1:0] m, input string tag);
    logic [NR-1:0] pend, g;
    int            budget;
    pend           = m;
    budget         = 0;
    bus.reqValidIn = pend;
    while (pend != '0 && budget < 100) begin
      @(negedge clk);
      g = bus.reqValidIn & bus.reqReadyOut;
      @(posedge clk); #1;
      pend           = pend & ~g;
      bus.reqValidIn = pend;
      budget++;
    end
    if (pend != '0) begin
      chk({tag, "_timeout"}, 32'(pend), 32'd0);
      bus.reqValidIn = '0;
    end
  endtask

  task automatic drain(input string tag);
    int bd;
    bd = 0;
    while ((exp_q.size() != 0 || bus.busyOut || bus.resValidOut) && bd < 200) begin
      @(posedge clk); #1;
      bd++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n          = 1'b0;
    bus.reqValidIn = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int bd;
    bd = 0;
    while (glog.size() < n && bd < budget) begin
      @(negedge clk);
      bd++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.reqValidIn = '0;
    bus.reqDataAIn = '0;
    bus.reqDataBIn = '0;
    for (int i = 0; i < NR; i++) set_op(i, 32'h0, 32'h0, 32'h0);

    // Outputs held at zero during reset even with requests pending
    repeat (2) @(posedge clk); #1;
    bus.reqValidIn = 4'hF;
    #1;
    chk("rst_ready", 32'(bus.reqReadyOut), 32'd0);
    chk("rst_res_valid", 32'(bus.resValidOut), 32'd0);
    chk("rst_res_id", 32'(bus.resIdOut), 32'd0);
    chk("rst_busy", 32'(bus.busyOut), 32'd0);
    bus.reqValidIn = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Single operation 1.0 * 2.0 from requester 0
    set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    glog.delete();
    drive_mask(4'b0001, "t1");
    repeat (2) @(posedge clk); #1;
    chk("t1_busy", 32'(bus.busyOut), 32'd1);
    drain("t1");
    chk("t1_ngnt", 32'(glog.size()), 32'd1);

    // Special values and rounding through requester 0
    set_op(0, 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000); drive_mask(4'b0001, "ovf");
    set_op(0, 32'h0000_0000, 32'hC040_0000, 32'h8000_0000); drive_mask(4'b0001, "zero");
    set_op(0, 32'h0080_0000, 32'h3F00_0000, 32'h0040_0000); drive_mask(4'b0001, "subn");
    set_op(0, 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002); drive_mask(4'b0001, "rdn");
    set_op(0, 32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002); drive_mask(4'b0001, "rup");
    drain("spec");

    // All four continuously valid from reset: strict 0,1,2,3 rotation, one per cycle
    do_reset();
    set_op(0, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000);
    set_op(1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    set_op(2, 32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000);
    set_op(3, 32'hC000_0000, 32'h4020_0000, 32'hC0A0_0000);
    glog.delete();
    bus.reqValidIn = 4'hF;
    wait_grants(12, 40);
    @(posedge clk); #1 bus.reqValidIn = '0;
    chk("rr_ngnt", 32'(glog.size() >= 12), 32'd1);
    for (int k = 0; k < 12; k++) begin
      if (k < glog.size()) chk("rr_id", 32'(glog[k].id), 32'(k % 4));
    end
    if (glog.size() >= 12) chk("rr_rate", 32'(glog[11].cyc - glog[0].cyc), 32'd11);
    drain("rr");

    // Requester 2 streaming alone: four grants, stall until first return, then one per return
    do_reset();
    glog.delete();
    bus.reqValidIn = 4'b0100;
    wait_grants(8, 60);
    @(posedge clk); #1 bus.reqValidIn = '0;
    chk("lim_ngnt", 32'(glog.size() >= 8), 32'd1);
    offs = '{0, 1, 2, 3, 11, 12, 13, 14};
    for (int k = 1; k < 8; k++) begin
      if (k < glog.size()) chk("lim_gap", 32'(glog[k].cyc - glog[0].cyc), 32'(offs[k]));
    end
    drain("lim");

    // ptr parked at 2: requester 3 wins over requester 1; requester 1 product is 3.0
    do_reset();
    set_op(1, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000);
    set_op(3, 32'hC000_0000, 32'h4020_0000, 32'hC0A0_0000);
    glog.delete();
    drive_mask(4'b0010, "ptr2");
    drive_mask(4'b1010, "pri");
    chk("pri_ngnt", 32'(glog.size()), 32'd3);
    if (glog.size() >= 3) begin
      chk("pri_first", 32'(glog[1].id), 32'd3);
      chk("pri_second", 32'(glog[2].id), 32'd1);
    end
    drain("pri");

    // Reset three cycles after issuing three operations discards them all
    do_reset();
    glog.delete();
    drive_mask(4'b0111, "abort");
    repeat (3) @(posedge clk); #1;
    rst_n          = 1'b0;
    bus.reqValidIn = 4'b0111;
    #1;
    chk("abort_busy", 32'(bus.busyOut), 32'd0);
    chk("abort_res_valid", 32'(bus.resValidOut), 32'd0);
    chk("abort_ready", 32'(bus.reqReadyOut), 32'd0);
    bus.reqValidIn = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    n0 = n_res;
    repeat (12) @(posedge clk); #1;
    chk("abort_no_res", 32'(n_res - n0), 32'd0);
    chk("abort_idle", 32'(bus.busyOut), 32'd0);
    glog.delete();
    drive_mask(4'b1001, "post");
    if (glog.size() >= 1) chk("post_first_id", 32'(glog[0].id), 32'd0);
    else chk("post_ngnt", 32'(glog.size()), 32'd2);
    // Requester 1 had an aborted operation; a cleared counter allows four back-to-back grants
    glog.delete();
    bus.reqValidIn = 4'b0010;
    wait_grants(5, 40);
    @(posedge clk); #1 bus.reqValidIn = '0;
    chk("post_ngnt5", 32'(glog.size() >= 5), 32'd1);
    for (int k = 1; k < 5; k++) begin
      if (k < glog.size()) chk("post_gap", 32'(glog[k].cyc - glog[0].cyc), 32'(offs[k]));
    end
    drain("post");

    b = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
